pocket_pad_arbiter: RTL and testbench
=====================================

Name: pocket_pad_arbiter

Overview:
- Shares the single player-input path of a one-player core between the four Pocket controller ports (cont1..cont4 key words).
- The first controller to press a button claims ownership after a lock-in period.
- Ownership is released after an idle timeout, or handed over on a Select+Start request while the owner is idle.
- Sits between the per-port synchronised key words and the gamepad decoder; a firmware/menu force-select overrides arbitration.

Parameters:
- LOCK_CYCLES, 4: cycles a candidate must stay active in LOCK before ownership is granted; must be ≥1.
- CNT_W, 24: width of the idle/lock counters.
- IDLE_TIMEOUT, 12000000: consecutive owner-idle cycles before release; must satisfy 1 ≤ IDLE_TIMEOUT < 2^CNT_W.

Ports:
- iCLK  in  1  system clock; all logic on posedge.
- iRST  in  1  asynchronous, active-high reset.
- iJOY1  in  32  port 1 key word, already synchronous to iCLK.
- iJOY2  in  32  port 2 key word, already synchronous to iCLK.
- iJOY3  in  32  port 3 key word, already synchronous to iCLK.
- iJOY4  in  32  port 4 key word, already synchronous to iCLK.
- iFORCE_EN  in  1  force ownership to iFORCE_SEL.
- iFORCE_SEL  in  2  forced port index (0..3 = port 1..4).
- oJOY  out  32  registered key word of the owner; 0 when unowned.
- oOWNER  out  2  current/last owner index.
- oOWNED  out  1  high while in OWNED or FORCED.
- oSWITCH  out  1  one-cycle pulse on the first cycle of each new OWNED grant.

Behaviour:
- Reset (async, iRST=1):
  - state=IDLE; oJOY=0, oOWNER=0, oOWNED=0, oSWITCH=0.
  - Lock and idle counters = 0; last_owner=3, so the round-robin search starts at port 0.
- Definitions:
  - active[n] = |iJOYn[15:0]; bits [31:16] never count as activity.
  - req[n] = iJOYn[14] & iJOYn[15] (Select+Start).
- Round-robin pick over a mask: the first set index searching last_owner+1, +2, +3, +4 (mod 4).
- States are IDLE, LOCK, OWNED and FORCED.
- IDLE:
  - If any active: cand <= pick(active), lock counter <= 0, go to LOCK.
  - oJOY=0.
- LOCK:
  - If !active[cand]: go to IDLE.
  - Else, if lock counter == LOCK_CYCLES-1: go to OWNED, oOWNER <= cand, last_owner <= cand, idle counter <= 0, oSWITCH=1 in the first OWNED cycle.
  - Else: lock counter++.
  - Grant therefore needs active[cand] for 1 IDLE sample + LOCK_CYCLES consecutive LOCK samples.
  - oJOY=0.
- OWNED:
  - oJOY <= iJOY[owner] each cycle, with one register stage. In the cycle state reads OWNED, oJOY holds the owner word sampled at the preceding edge.
  - Idle counter clears on any active[owner]; otherwise it increments.
  - If !active[owner] and the idle counter == IDLE_TIMEOUT-1: go to IDLE (release after IDLE_TIMEOUT consecutive idle samples); oJOY=0 from the next cycle.
  - Takeover: if !active[owner] and some non-owner n has req[n], then cand <= pick(req & ~onehot(owner)) and go to LOCK. Takeover has priority over the timeout in the same cycle.
- FORCED:
  - Entered from any state on the edge where iFORCE_EN=1.
  - oOWNER <= iFORCE_SEL, which is tracked live while in FORCED; oJOY <= iJOY[iFORCE_SEL].
  - No timeout, no takeover, no oSWITCH pulse.
  - On iFORCE_EN=0: go to IDLE, oJOY=0, idle and lock counters cleared; last_owner keeps the last forced index.
- Precedence: reset > force > takeover > timeout > normal transitions.
- Simultaneous activity in IDLE: resolved only by round-robin; there is no fixed priority.
- Counters saturate, never wrap; the comparisons stop them at their terminal values.
- Reset mid-LOCK or mid-OWNED immediately zeroes oJOY and oOWNED; no partial grant survives.

Test Plan:
- Lock-in: LOCK_CYCLES=2, IDLE_TIMEOUT=8; iJOY2=0x0010 held -> after 3 active samples oOWNED=1, oOWNER=1, oSWITCH one cycle, oJOY=0x0010 in that cycle.
- Lock abort: iJOY3=0x0001 for 2 cycles then 0 -> LOCK aborts to IDLE; oOWNED never rises; oJOY stays 0.
- Timeout and round-robin:
  - Owner port 1 releases all buttons -> exactly 8 idle cycles later oOWNED=0, oJOY=0.
  - Then iJOY1 and iJOY3 both =0x0020 simultaneously -> grant goes to port 2 (index 2, next after last_owner=1).
- Takeover: owner 0 idle, iJOY4=0xC000 held -> LOCK then oOWNER=3 with oSWITCH. Repeat with owner holding 0x0004 -> no takeover.
- Force: iFORCE_EN=1, iFORCE_SEL=2 while port 0 owns -> next cycle oOWNER=2, oJOY=iJOY3, no oSWITCH, no timeout after 20 idle cycles. Drop iFORCE_EN -> IDLE, oJOY=0.
- Async reset: assert iRST mid-OWNED between clock edges -> oJOY=0, oOWNED=0, oOWNER=0 immediately without a clock edge; after release, arbitration restarts at port 0.

Source files
------------

// File: rtl/pocket_pad_arbiter.sv
// Arbitrates the four Pocket controller key words onto one player-input path.
// First active port wins after a lock-in; ownership ends on idle timeout, Select+Start takeover or force.
module pocket_pad_arbiter #(
    parameter int LOCK_CYCLES  = 4,
    parameter int CNT_W        = 24,
    parameter int IDLE_TIMEOUT = 12000000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iJOY1,
    input  logic [31:0] iJOY2,
    input  logic [31:0] iJOY3,
    input  logic [31:0] iJOY4,
    input  logic        iFORCE_EN,
    input  logic [1:0]  iFORCE_SEL,
    output logic [31:0] oJOY,
    output logic [1:0]  oOWNER,
    output logic        oOWNED,
    output logic        oSWITCH
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_OWNED  = 2'd2,
        ST_FORCED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    // Descending scan so the nearest set index after 'last' is the final assignment.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] sel;
        sel = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            sel = mask[idx] ? idx : sel;
        end
        return sel;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       last_owner_q, last_owner_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [31:0]      joy_q, joy_d;
    logic             owned_q, owned_d;
    logic             switch_q, switch_d;

    logic [31:0]      joy_s [4];
    logic [3:0]       active_s;
    logic [3:0]       req_s;
    logic [3:0]       owner_oh_s;
    logic [3:0]       takeover_mask_s;

    assign joy_s[0] = iJOY1;
    assign joy_s[1] = iJOY2;
    assign joy_s[2] = iJOY3;
    assign joy_s[3] = iJOY4;

    // Per-port activity and Select+Start request decode
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            active_s[n] = |joy_s[n][15:0];
            req_s[n]    = joy_s[n][14] & joy_s[n][15];
        end
        owner_oh_s      = 4'b0001 << owner_q;
        takeover_mask_s = req_s & ~owner_oh_s;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        joy_d        = 32'h0000_0000;
        switch_d     = 1'b0;

        if (iFORCE_EN) begin
            state_d      = ST_FORCED;
            owner_d      = iFORCE_SEL;
            last_owner_d = iFORCE_SEL;
            lock_cnt_d   = {CNT_W{1'b0}};
            idle_cnt_d   = {CNT_W{1'b0}};
            joy_d        = joy_s[iFORCE_SEL];
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|active_s) begin
                        cand_d     = rr_pick(active_s, last_owner_q);
                        lock_cnt_d = {CNT_W{1'b0}};
                        state_d    = ST_LOCK;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (!active_s[cand_q]) begin
                        state_d      = ST_IDLE;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d      = ST_OWNED;
                        owner_d      = cand_q;
                        last_owner_d = cand_q;
                        idle_cnt_d   = {CNT_W{1'b0}};
                        switch_d     = 1'b1;
                        joy_d        = joy_s[cand_q];
                    end else begin
                        lock_cnt_d   = lock_cnt_q + CNT_W'(1);
                    end
                end
                ST_OWNED: begin
                    if (active_s[owner_q]) begin
                        idle_cnt_d = {CNT_W{1'b0}};
                        joy_d      = joy_s[owner_q];
                    end else if (|takeover_mask_s) begin
                        // Takeover outranks a timeout landing on the same cycle.
                        cand_d     = rr_pick(takeover_mask_s, last_owner_q);
                        lock_cnt_d = {CNT_W{1'b0}};
                        state_d    = ST_LOCK;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                        joy_d      = joy_s[owner_q];
                    end
                end
                ST_FORCED: begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = {CNT_W{1'b0}};
                    idle_cnt_d = {CNT_W{1'b0}};
                end
                default: begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = {CNT_W{1'b0}};
                    idle_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end

        owned_d = (state_d == ST_OWNED) || (state_d == ST_FORCED);
    end

    // State, counter and output registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= ST_IDLE;
            cand_q       <= 2'd0;
            last_owner_q <= 2'd3;
            owner_q      <= 2'd0;
            lock_cnt_q   <= {CNT_W{1'b0}};
            idle_cnt_q   <= {CNT_W{1'b0}};
            joy_q        <= 32'h0000_0000;
            owned_q      <= 1'b0;
            switch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            joy_q        <= joy_d;
            owned_q      <= owned_d;
            switch_q     <= switch_d;
        end
    end

    assign oJOY    = joy_q;
    assign oOWNER  = owner_q;
    assign oOWNED  = owned_q;
    assign oSWITCH = switch_q;

endmodule

// File: tb/tb_pocket_pad_arbiter.sv
// Bench for pocket_pad_arbiter: directed scenarios plus randomized traffic
// checked against a sample-counting reference model.
module tb_pocket_pad_arbiter;

    localparam int LC = 2;
    localparam int TO = 8;
    localparam int M_FREE  = 0;
    localparam int M_LOCK  = 1;
    localparam int M_OWN   = 2;
    localparam int M_FORCE = 3;

    logic        iCLK;
    logic        iRST;
    logic [31:0] iJOY1, iJOY2, iJOY3, iJOY4;
    logic        iFORCE_EN;
    logic [1:0]  iFORCE_SEL;
    logic [31:0] oJOY;
    logic [1:0]  oOWNER;
    logic        oOWNED;
    logic        oSWITCH;

    int n_cmp;
    int n_bad;

    // Reference model state
    int          m_mode;
    int          m_last;
    int          m_cand;
    int          m_streak;
    int          m_idle;
    logic [31:0] exp_joy;
    logic [1:0]  exp_owner;
    logic        exp_owned;
    logic        exp_switch;

    pocket_pad_arbiter #(
        .LOCK_CYCLES (LC),
        .CNT_W       (24),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iJOY1     (iJOY1),
        .iJOY2     (iJOY2),
        .iJOY3     (iJOY3),
        .iJOY4     (iJOY4),
        .iFORCE_EN (iFORCE_EN),
        .iFORCE_SEL(iFORCE_SEL),
        .oJOY      (oJOY),
        .oOWNER    (oOWNER),
        .oOWNED    (oOWNED),
        .oSWITCH   (oSWITCH)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    function automatic int rr_pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_FREE; m_last = 3; m_cand = 0; m_streak = 0; m_idle = 0;
        exp_joy = 32'h0; exp_owner = 2'd0; exp_owned = 1'b0; exp_switch = 1'b0;
    endtask

    // Advances the model by one sampled clock edge using the held inputs.
    task automatic model_step();
        logic [31:0] w [4];
        logic [3:0]  act;
        logic [3:0]  rq;
        int          own;
        w[0] = iJOY1; w[1] = iJOY2; w[2] = iJOY3; w[3] = iJOY4;
        if (iRST) begin
            model_reset();
            return;
        end
        for (int n = 0; n < 4; n++) begin
            act[n] = (w[n][15:0] != 16'h0);
            rq[n]  = (w[n][15:14] == 2'b11);
        end
        exp_switch = 1'b0;
        own = int'(exp_owner);
        if (iFORCE_EN) begin
            m_mode = M_FORCE; exp_owner = iFORCE_SEL; m_last = int'(iFORCE_SEL);
            exp_joy = w[iFORCE_SEL];
        end else if (m_mode == M_FREE) begin
            exp_joy = 32'h0;
            if (act != 4'h0) begin
                m_cand = rr_pick(act, m_last); m_streak = 0; m_mode = M_LOCK;
            end
        end else if (m_mode == M_LOCK) begin
            exp_joy = 32'h0;
            if (!act[m_cand]) begin
                m_mode = M_FREE;
            end else begin
                m_streak++;
                if (m_streak == LC) begin
                    m_mode = M_OWN; exp_owner = 2'(m_cand); m_last = m_cand;
                    m_idle = 0; exp_switch = 1'b1; exp_joy = w[m_cand];
                end
            end
        end else if (m_mode == M_OWN) begin
            rq[own] = 1'b0;
            if (act[own]) begin
                m_idle = 0; exp_joy = w[own];
            end else if (rq != 4'h0) begin
                m_cand = rr_pick(rq, m_last); m_streak = 0; m_mode = M_LOCK; exp_joy = 32'h0;
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_mode = M_FREE; exp_joy = 32'h0;
                end else begin
                    exp_joy = w[own];
                end
            end
        end else begin
            m_mode = M_FREE; exp_joy = 32'h0;
        end
        exp_owned = (m_mode == M_OWN) || (m_mode == M_FORCE);
    endtask

    task automatic tick();
        @(posedge iCLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        iRST = 1'b1; iFORCE_EN = 1'b0; iFORCE_SEL = 2'd0;
        iJOY1 = 32'h0000_0001; iJOY2 = 32'h0; iJOY3 = 32'h0; iJOY4 = 32'h0;
        model_reset();
        repeat (3) tick();
        n_cmp++; if (oJOY !== 32'h0)   begin n_bad++; $display("FAIL reset_joy: got %h expected %h", oJOY, 32'h0); end
        n_cmp++; if (oOWNER !== 2'd0)  begin n_bad++; $display("FAIL reset_owner: got %0d expected 0", oOWNER); end
        n_cmp++; if (oOWNED !== 1'b0)  begin n_bad++; $display("FAIL reset_owned: got %b expected 0", oOWNED); end
        n_cmp++; if (oSWITCH !== 1'b0) begin n_bad++; $display("FAIL reset_switch: got %b expected 0", oSWITCH); end
        iJOY1 = 32'h0;
        iRST = 1'b0;
    endtask

    task automatic test_lock_in();
        iJOY2 = 32'h0000_0010;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++; if (oOWNED !== 1'b0) begin n_bad++; $display("FAIL lockin_early_owned: cycle %0d got %b expected 0", i, oOWNED); end
        end
        tick();
        n_cmp++; if (oOWNED !== 1'b1)       begin n_bad++; $display("FAIL lockin_owned: got %b expected 1", oOWNED); end
        n_cmp++; if (oOWNER !== 2'd1)       begin n_bad++; $display("FAIL lockin_owner: got %0d expected 1", oOWNER); end
        n_cmp++; if (oSWITCH !== 1'b1)      begin n_bad++; $display("FAIL lockin_switch: got %b expected 1", oSWITCH); end
        n_cmp++; if (oJOY !== 32'h0000_0010) begin n_bad++; $display("FAIL lockin_joy: got %h expected %h", oJOY, 32'h10); end
        tick();
        n_cmp++; if (oSWITCH !== 1'b0)      begin n_bad++; $display("FAIL lockin_switch_pulse: got %b expected 0", oSWITCH); end
    endtask

    task automatic test_timeout_rr();
        iJOY2 = 32'h0;
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (i < TO) begin
                n_cmp++; if (oOWNED !== 1'b1) begin n_bad++; $display("FAIL timeout_early: idle %0d got %b expected 1", i, oOWNED); end
            end else begin
                n_cmp++; if (oOWNED !== 1'b0) begin n_bad++; $display("FAIL timeout_release: got %b expected 0", oOWNED); end
                n_cmp++; if (oJOY !== 32'h0)  begin n_bad++; $display("FAIL timeout_joy: got %h expected 0", oJOY); end
            end
        end
        iJOY1 = 32'h0000_0020; iJOY3 = 32'h0000_0020;
        repeat (LC + 1) tick();
        n_cmp++; if (oOWNER !== 2'd2)  begin n_bad++; $display("FAIL rr_owner: got %0d expected 2", oOWNER); end
        n_cmp++; if (oSWITCH !== 1'b1) begin n_bad++; $display("FAIL rr_switch: got %b expected 1", oSWITCH); end
        iJOY1 = 32'h0; iJOY3 = 32'h0;
        repeat (TO) tick();
    endtask

    task automatic test_lock_abort();
        iJOY3 = 32'h0000_0001;
        repeat (2) tick();
        iJOY3 = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (oOWNED !== 1'b0 || oJOY !== 32'h0) begin
                n_bad++; $display("FAIL lock_abort: cycle %0d got owned=%b joy=%h expected owned=0 joy=0", i, oOWNED, oJOY);
            end
        end
    endtask

    task automatic test_takeover();
        iJOY1 = 32'h0000_0001;
        repeat (LC + 1) tick();
        n_cmp++; if (oOWNER !== 2'd0 || oOWNED !== 1'b1) begin n_bad++; $display("FAIL takeover_setup: got owner=%0d owned=%b expected 0/1", oOWNER, oOWNED); end
        iJOY1 = 32'h0; iJOY4 = 32'h0000_C000;
        tick();
        n_cmp++; if (oOWNED !== 1'b0) begin n_bad++; $display("FAIL takeover_lock: got owned=%b expected 0", oOWNED); end
        repeat (LC) tick();
        n_cmp++; if (oOWNER !== 2'd3 || oSWITCH !== 1'b1 || oJOY !== 32'h0000_C000) begin
            n_bad++; $display("FAIL takeover_grant: got owner=%0d switch=%b joy=%h expected 3/1/0000c000", oOWNER, oSWITCH, oJOY);
        end
        iJOY4 = 32'h0;
        repeat (TO) tick();
        iJOY1 = 32'h0000_0004;
        repeat (LC + 1) tick();
        iJOY4 = 32'h0000_C000;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (oOWNER !== 2'd0 || oOWNED !== 1'b1 || oSWITCH !== 1'b0) begin
                n_bad++; $display("FAIL no_takeover: cycle %0d got owner=%0d owned=%b switch=%b expected 0/1/0", i, oOWNER, oOWNED, oSWITCH);
            end
        end
        iJOY4 = 32'h0;
    endtask

    task automatic test_force();
        iJOY1 = 32'h0; iJOY3 = 32'h5A5A_0000;
        iFORCE_EN = 1'b1; iFORCE_SEL = 2'd2;
        tick();
        n_cmp++; if (oOWNER !== 2'd2 || oJOY !== 32'h5A5A_0000 || oSWITCH !== 1'b0 || oOWNED !== 1'b1) begin
            n_bad++; $display("FAIL force_enter: got owner=%0d joy=%h switch=%b owned=%b expected 2/5a5a0000/0/1", oOWNER, oJOY, oSWITCH, oOWNED);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (oOWNED !== 1'b1 || oOWNER !== 2'd2) begin
                n_bad++; $display("FAIL force_hold: cycle %0d got owned=%b owner=%0d expected 1/2", i, oOWNED, oOWNER);
            end
        end
        iFORCE_SEL = 2'd1; iJOY2 = 32'h0000_0003;
        tick();
        n_cmp++; if (oOWNER !== 2'd1 || oJOY !== 32'h0000_0003) begin
            n_bad++; $display("FAIL force_live_sel: got owner=%0d joy=%h expected 1/00000003", oOWNER, oJOY);
        end
        iJOY2 = 32'h0; iJOY3 = 32'h0; iFORCE_EN = 1'b0;
        tick();
        n_cmp++; if (oOWNED !== 1'b0 || oJOY !== 32'h0) begin
            n_bad++; $display("FAIL force_exit: got owned=%b joy=%h expected 0/0", oOWNED, oJOY);
        end
        iJOY1 = 32'h1; iJOY2 = 32'h1; iJOY3 = 32'h1; iJOY4 = 32'h1;
        repeat (LC + 1) tick();
        n_cmp++; if (oOWNER !== 2'd2) begin n_bad++; $display("FAIL force_last_owner_rr: got %0d expected 2", oOWNER); end
    endtask

    task automatic test_async_reset();
        #2;
        iRST = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (oJOY !== 32'h0 || oOWNED !== 1'b0 || oOWNER !== 2'd0) begin
            n_bad++; $display("FAIL async_reset: got joy=%h owned=%b owner=%0d expected 0/0/0", oJOY, oOWNED, oOWNER);
        end
        tick();
        iRST = 1'b0;
        repeat (LC + 1) tick();
        n_cmp++; if (oOWNER !== 2'd0 || oOWNED !== 1'b1 || oJOY !== 32'h1) begin
            n_bad++; $display("FAIL async_restart: got owner=%0d owned=%b joy=%h expected 0/1/00000001", oOWNER, oOWNED, oJOY);
        end
        iJOY1 = 32'h0; iJOY2 = 32'h0; iJOY3 = 32'h0; iJOY4 = 32'h0;
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4) return 32'h0;
        if (r == 5) return 32'h0000_C000 | ($urandom() & 32'hFFFF_0000);
        if (r == 6) return $urandom() & 32'hFFFF_0000;
        return (32'h1 << $urandom_range(0, 15)) | ($urandom() & 32'hFFFF_0000);
    endfunction

    task automatic test_random();
        for (int seg = 0; seg < 300; seg++) begin
            iJOY1 = rand_word(); iJOY2 = rand_word(); iJOY3 = rand_word(); iJOY4 = rand_word();
            iFORCE_EN  = ($urandom_range(0, 14) == 0);
            iFORCE_SEL = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 12)) begin
                tick();
                n_cmp++; if (oJOY !== exp_joy)       begin n_bad++; $display("FAIL rand_joy: seg %0d got %h expected %h", seg, oJOY, exp_joy); end
                n_cmp++; if (oOWNER !== exp_owner)   begin n_bad++; $display("FAIL rand_owner: seg %0d got %0d expected %0d", seg, oOWNER, exp_owner); end
                n_cmp++; if (oOWNED !== exp_owned)   begin n_bad++; $display("FAIL rand_owned: seg %0d got %b expected %b", seg, oOWNED, exp_owned); end
                n_cmp++; if (oSWITCH !== exp_switch) begin n_bad++; $display("FAIL rand_switch: seg %0d got %b expected %b", seg, oSWITCH, exp_switch); end
            end
        end
        iFORCE_EN = 1'b0;
        iJOY1 = 32'h0; iJOY2 = 32'h0; iJOY3 = 32'h0; iJOY4 = 32'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_lock_in();
        test_timeout_rr();
        test_lock_abort();
        test_takeover();
        test_force();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
